// File: rtl/wb_queue_pkg.sv
// Shared writeback types: writeback-source select, per-entry state and the
// queue entry record used by wb_queue and wb_load_align.
package rv32i_types;

  localparam int XLEN_MAX = 64;

  typedef enum logic [3:0] {
    WB_ALU = 4'd0,
    WB_BR  = 4'd1,
    WB_PC4 = 4'd2,
    WB_LW  = 4'd3,
    WB_LH  = 4'd4,
    WB_LHU = 4'd5,
    WB_LB  = 4'd6,
    WB_LBU = 4'd7,
    WB_LD  = 4'd8,
    WB_LWU = 4'd9
  } wbmux_sel_t;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } entry_state_t;

  // data/pc are sized for the widest datapath; narrower builds use the low bits
  typedef struct packed {
    entry_state_t          state;
    wbmux_sel_t            wb_sel;
    logic [4:0]            rd;
    logic [2:0]            addr_lo;
    logic [XLEN_MAX-1:0]   data;
    logic [XLEN_MAX-1:0]   pc;
    logic                  misalign;
  } wb_entry_t;

  function automatic logic is_load(input wbmux_sel_t sel, input logic wide);
    logic res;
    case (sel)
      WB_LW, WB_LH, WB_LHU, WB_LB, WB_LBU: res = 1'b1;
      WB_LD, WB_LWU:                       res = wide;
      default:                             res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_queue_if.sv
// Allocation, load-response and register-file writeback bundle of wb_queue.
// master = the pipeline side driving allocations/responses, slave = the queue.
interface wb_queue_if
  import rv32i_types::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int TAGW = $clog2(DEPTH);

  logic            alloc_valid;
  logic            alloc_ready;
  wbmux_sel_t      alloc_wb_sel;
  logic [4:0]      alloc_rd;
  logic [XLEN-1:0] alloc_alu_out;
  logic            alloc_br_en;
  logic [XLEN-1:0] alloc_pc;
  logic [TAGW-1:0] alloc_tag;

  logic            resp_valid;
  logic [TAGW-1:0] resp_tag;
  logic [XLEN-1:0] resp_rdata;

  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic [XLEN-1:0] wb_pc;
  logic            misalign_err;
  logic [TAGW:0]   count;

  modport master (
    output alloc_valid, alloc_wb_sel, alloc_rd, alloc_alu_out, alloc_br_en, alloc_pc,
    output resp_valid, resp_tag, resp_rdata,
    input  alloc_ready, alloc_tag, rf_we, rf_rd, rf_wdata, wb_pc, misalign_err, count
  );

  modport slave (
    input  alloc_valid, alloc_wb_sel, alloc_rd, alloc_alu_out, alloc_br_en, alloc_pc,
    input  resp_valid, resp_tag, resp_rdata,
    output alloc_ready, alloc_tag, rf_we, rf_rd, rf_wdata, wb_pc, misalign_err, count
  );

endinterface

// File: rtl/wb_load_align.sv
// Combinational load extraction: shifts the response word by the byte offset,
// sign/zero-extends per load type and flags misaligned accesses.
module wb_load_align
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  wbmux_sel_t      wb_sel,
  input  logic [2:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            misalign
);
  localparam int OFFW = $clog2(XLEN / 8);

  logic [XLEN-1:0] shifted_s;

  assign shifted_s = rdata >> {addr_lo[OFFW-1:0], 3'b000};

  // Extend the selected lane and check natural alignment
  always_comb begin
    data     = rdata;
    misalign = 1'b0;
    case (wb_sel)
      WB_LB:  data = XLEN'($signed(shifted_s[7:0]));
      WB_LBU: data = XLEN'(shifted_s[7:0]);
      WB_LH: begin
        data     = XLEN'($signed(shifted_s[15:0]));
        misalign = addr_lo[0];
      end
      WB_LHU: begin
        data     = XLEN'(shifted_s[15:0]);
        misalign = addr_lo[0];
      end
      WB_LW: begin
        data     = XLEN'($signed(shifted_s[31:0]));
        misalign = (addr_lo[1:0] != 2'b00);
      end
      WB_LWU: begin
        data     = XLEN'(shifted_s[31:0]);
        misalign = (addr_lo[1:0] != 2'b00);
      end
      WB_LD: begin
        data     = shifted_s;
        misalign = (addr_lo != 3'b000);
      end
      default: begin
        data     = rdata;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/wb_queue.sv
// In-order writeback queue: entries wait for load data, then retire one per
// cycle from the head into registered register-file write outputs.
module wb_queue
  import rv32i_types::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  wb_queue_if.slave  bus
);
  localparam int TAGW = $clog2(DEPTH);
  localparam logic [TAGW:0] DEPTH_C = (TAGW + 1)'(DEPTH);
  localparam logic WIDE = (XLEN == 64);

  wb_entry_t       entries_r   [DEPTH];
  wb_entry_t       entries_n_s [DEPTH];
  wb_entry_t       new_e_s;
  logic [TAGW-1:0] head_r, head_n_s, tail_r, tail_n_s;
  logic [TAGW:0]   count_r, count_n_s;
  logic            alloc_fire_s, retire_s, resp_hit_s;
  logic            ret_mis_s, ret_wr_s;
  logic [XLEN-1:0] ld_data_s;
  logic            ld_mis_s;

  logic            rf_we_r, misalign_err_r;
  logic [4:0]      rf_rd_r;
  logic [XLEN-1:0] rf_wdata_r, wb_pc_r;

  assign bus.alloc_ready  = (count_r < DEPTH_C) && !flush;
  assign bus.alloc_tag    = tail_r;
  assign bus.count        = count_r;
  assign bus.rf_we        = rf_we_r;
  assign bus.rf_rd        = rf_rd_r;
  assign bus.rf_wdata     = rf_wdata_r;
  assign bus.wb_pc        = wb_pc_r;
  assign bus.misalign_err = misalign_err_r;

  assign alloc_fire_s = bus.alloc_valid && bus.alloc_ready;
  assign resp_hit_s   = bus.resp_valid && !flush && (entries_r[bus.resp_tag].state == ST_WAIT);
  assign retire_s     = !flush && (entries_r[head_r].state == ST_READY);
  assign ret_mis_s    = entries_r[head_r].misalign;
  assign ret_wr_s     = retire_s && !ret_mis_s && (entries_r[head_r].rd != 5'd0);

  wb_load_align #(.XLEN(XLEN)) u_align (
    .wb_sel   (entries_r[bus.resp_tag].wb_sel),
    .addr_lo  (entries_r[bus.resp_tag].addr_lo),
    .rdata    (bus.resp_rdata),
    .data     (ld_data_s),
    .misalign (ld_mis_s)
  );

  // Build the entry for an incoming allocation
  always_comb begin
    new_e_s         = '0;
    new_e_s.wb_sel  = bus.alloc_wb_sel;
    new_e_s.rd      = bus.alloc_rd;
    new_e_s.addr_lo = bus.alloc_alu_out[2:0];
    new_e_s.pc      = XLEN_MAX'(bus.alloc_pc);
    if (is_load(bus.alloc_wb_sel, WIDE)) begin
      new_e_s.state = ST_WAIT;
    end else begin
      new_e_s.state = ST_READY;
      case (bus.alloc_wb_sel)
        WB_BR:   new_e_s.data = XLEN_MAX'(bus.alloc_br_en);
        WB_PC4:  new_e_s.data = XLEN_MAX'(bus.alloc_pc + XLEN'(3'd4));
        default: new_e_s.data = XLEN_MAX'(bus.alloc_alu_out);
      endcase
    end
  end

  // Next queue state: flush, response fill, head retire, tail allocate
  always_comb begin
    entries_n_s = entries_r;
    head_n_s    = head_r;
    tail_n_s    = tail_r;
    count_n_s   = count_r;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_n_s[i] = '0;
      end
      head_n_s  = '0;
      tail_n_s  = '0;
      count_n_s = '0;
    end else begin
      if (resp_hit_s) begin
        entries_n_s[bus.resp_tag].state    = ST_READY;
        entries_n_s[bus.resp_tag].data     = XLEN_MAX'(ld_data_s);
        entries_n_s[bus.resp_tag].misalign = ld_mis_s;
      end
      if (retire_s) begin
        entries_n_s[head_r] = '0;
        head_n_s            = head_r + 1'b1;
      end
      if (alloc_fire_s) begin
        entries_n_s[tail_r] = new_e_s;
        tail_n_s            = tail_r + 1'b1;
      end
      count_n_s = count_r + (TAGW + 1)'(alloc_fire_s) - (TAGW + 1)'(retire_s);
    end
  end

  // Queue state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      entries_r <= entries_n_s;
      head_r    <= head_n_s;
      tail_r    <= tail_n_s;
      count_r   <= count_n_s;
    end
  end

  // Registered writeback; data outputs only move on an actual write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_r        <= 1'b0;
      misalign_err_r <= 1'b0;
      rf_rd_r        <= 5'd0;
      rf_wdata_r     <= '0;
      wb_pc_r        <= '0;
    end else begin
      rf_we_r        <= ret_wr_s;
      misalign_err_r <= retire_s && ret_mis_s;
      if (ret_wr_s) begin
        rf_rd_r    <= entries_r[head_r].rd;
        rf_wdata_r <= XLEN'(entries_r[head_r].data);
        wb_pc_r    <= XLEN'(entries_r[head_r].pc);
      end else begin
        rf_rd_r    <= rf_rd_r;
        rf_wdata_r <= rf_wdata_r;
        wb_pc_r    <= wb_pc_r;
      end
    end
  end

endmodule
